// File: rtl/rx_uart_frontend.sv
// 8N1 UART receiver front end: synchronizer, bit-timing FSM and a one-deep
// holding register with ready/valid handoff, frame-error pulse and sticky overrun.
module rx_uart_frontend #(
   parameter int unsigned DIV = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   input  logic       ovr_clr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned TW = $clog2(DIV);
   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t          state, state_next;
   logic [TW-1:0]   timer, timer_next;
   logic [2:0]      index, index_next;
   logic [7:0]      shift, shift_next;
   logic            rx_meta, rxs;

   logic [7:0]      data_next;
   logic            valid_next, fe_next, ovr_next, busy_next;
   logic            stop_tick;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // State and bit-timing registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         index <= '0;
         shift <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
         index <= index_next;
         shift <= shift_next;
      end
   end

   // Next-state and bit-timing logic
   always_comb begin
      state_next = state;
      timer_next = timer + TW'(1);
      index_next = index;
      shift_next = shift;
      unique case (state)
         IDLE: begin
            timer_next = '0;
            if (!rxs) state_next = START;
         end
         START: begin
            if (timer == T_HALF) begin
               timer_next = '0;
               index_next = '0;
               state_next = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == T_LAST) begin
               timer_next        = '0;
               shift_next[index] = rxs;
               index_next        = index + 3'd1;
               if (index == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (timer == T_LAST) begin
               timer_next = '0;
               state_next = rxs ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            timer_next = '0;
            if (rxs) state_next = IDLE;
         end
         default: begin
            timer_next = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Output / holding-register next values
   always_comb begin
      stop_tick  = (state == STOP) && (timer == T_LAST);
      data_next  = rx_data;
      valid_next = rx_valid;
      ovr_next   = overrun;
      fe_next    = stop_tick && !rxs;
      busy_next  = (state_next != IDLE);
      if (rx_valid && rx_ready) valid_next = 1'b0;
      if (ovr_clr) ovr_next = 1'b0;
      if (stop_tick && rxs) begin
         if (!rx_valid || rx_ready) begin
            data_next  = shift;
            valid_next = 1'b1;
         end else begin
            ovr_next = 1'b1;
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_data   <= data_next;
         rx_valid  <= valid_next;
         frame_err <= fe_next;
         overrun   <= ovr_next;
         busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_rx_uart_frontend.sv
// Directed bench for rx_uart_frontend at DIV=8: delivery, latency, overrun,
// frame error / break, glitch rejection, mid-frame reset and streaming.
module tb_rx_uart_frontend;

   localparam int unsigned DIV = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic       ovr_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fe_cnt    = 0;
   int vcyc      = 0;
   logic [7:0] cap[$];

   rx_uart_frontend #(.DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_ready  (rx_ready),
      .ovr_clr   (ovr_clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Passive monitor on the falling edge
   always @(negedge clk) begin
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (rx_valid) vcyc = vcyc + 1;
      if (rx_valid && rx_ready) cap.push_back(rx_data);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(DIV);
      end
      rx = stop;
      tick(DIV);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
      tick(3);
      total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", rx_data); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid); else pass_cnt++;
      total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_fe got %b want 0", frame_err); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_basic();
      int fe0;
      fe0 = fe_cnt;
      fork
         send_byte(8'hA5, 1'b1);
         begin
            repeat (78) @(posedge clk);
            @(negedge clk);
            total_cnt++; if (rx_valid !== 1'b0) $display("FAIL lat_early got %b want 0", rx_valid); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (rx_valid !== 1'b1) $display("FAIL lat_rise got %b want 1", rx_valid); else pass_cnt++;
         end
      join
      tick(2);
      total_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", rx_valid); else pass_cnt++;
      total_cnt++; if (rx_data !== 8'hA5) $display("FAIL basic_data got %h want a5", rx_data); else pass_cnt++;
      total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL basic_fe got %0d want 0", fe_cnt - fe0); else pass_cnt++;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", rx_valid); else pass_cnt++;
      total_cnt++; if (rx_data !== 8'hA5) $display("FAIL basic_hold got %h want a5", rx_data); else pass_cnt++;
      tick(2);
   endtask

   task automatic test_overrun();
      send_byte(8'h3C, 1'b1);
      send_byte(8'h81, 1'b1);
      tick(2);
      total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", rx_valid); else pass_cnt++;
      total_cnt++; if (rx_data !== 8'h3C) $display("FAIL ovr_data got %h want 3c", rx_data); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else pass_cnt++;
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_clr_valid got %b want 1", rx_valid); else pass_cnt++;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(2);
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      send_byte(8'h55, 1'b0);
      tick(40);
      total_cnt++; if (busy !== 1'b1) $display("FAIL brk_busy got %b want 1", busy); else pass_cnt++;
      total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL brk_fe_cnt got %0d want 1", fe_cnt - fe0); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL brk_valid got %b want 0", rx_valid); else pass_cnt++;
      rx = 1'b1;
      tick(5);
      total_cnt++; if (busy !== 1'b0) $display("FAIL brk_idle got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL brk_fe_after got %0d want 1", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(2);
      total_cnt++; if (busy !== 1'b1) $display("FAIL glitch_start got %b want 1", busy); else pass_cnt++;
      tick(10);
      total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_idle got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid got %b want 0", rx_valid); else pass_cnt++;
      total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int fe0;
      int n0;
      fe0 = fe_cnt;
      n0  = cap.size();
      rx = 1'b0;
      tick(DIV);
      rx = 1'b1;
      tick(4 * DIV + DIV / 2);
      rst = 1'b1;
      tick(2);
      total_cnt++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", busy); else pass_cnt++;
      rst = 1'b0;
      tick(10);
      total_cnt++; if (busy !== 1'b0) $display("FAIL mrst_idle got %b want 0", busy); else pass_cnt++;
      send_byte(8'h12, 1'b1);
      tick(2);
      total_cnt++; if (rx_valid !== 1'b1) $display("FAIL mrst_valid got %b want 1", rx_valid); else pass_cnt++;
      total_cnt++; if (rx_data !== 8'h12) $display("FAIL mrst_data got %h want 12", rx_data); else pass_cnt++;
      total_cnt++; if (overrun !== 1'b0) $display("FAIL mrst_ovr got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL mrst_fe got %0d want 0", fe_cnt - fe0); else pass_cnt++;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      total_cnt++; if (cap.size() - n0 !== 1) $display("FAIL mrst_count got %0d want 1", cap.size() - n0); else pass_cnt++;
      tick(2);
   endtask

   task automatic test_back_to_back();
      int n0;
      int v0;
      logic [7:0] b;
      n0 = cap.size();
      v0 = vcyc;
      rx_ready = 1'b1;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      tick(3);
      rx_ready = 1'b0;
      total_cnt++; if (cap.size() - n0 !== 2) $display("FAIL b2b_count got %0d want 2", cap.size() - n0); else pass_cnt++;
      total_cnt++; if (vcyc - v0 !== 2) $display("FAIL b2b_vcyc got %0d want 2", vcyc - v0); else pass_cnt++;
      if (cap.size() - n0 >= 2) begin
         b = cap[n0];
         total_cnt++; if (b !== 8'h00) $display("FAIL b2b_first got %h want 00", b); else pass_cnt++;
         b = cap[n0 + 1];
         total_cnt++; if (b !== 8'hFF) $display("FAIL b2b_second got %h want ff", b); else pass_cnt++;
      end
      total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_ovr got %b want 0", overrun); else pass_cnt++;
      total_cnt++; if (rx_valid !== 1'b0) $display("FAIL b2b_valid got %b want 0", rx_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rx_uart_frontend.md
RX_UART_FRONTEND -- requirements
Module: rx_uart_frontend

Interface
REQ-001 Parameter DIV, default 104, clock cycles per UART bit; legal range 4..4095; even values only.
REQ-002 clk  input  1  sole clock; all flops rising-edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high, synchronous release handled by the parent.
REQ-004 rx  input  1  asynchronous serial line (idle high), 8N1, LSB first; driven from a ui_in pin.
REQ-005 rx_ready  input  1  consumer ready; a byte transfers on a cycle with rx_valid=1 and rx_ready=1.
REQ-006 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-007 rx_data  output  8  received byte; stable whenever rx_valid=1.
REQ-008 rx_valid  output  1  holding register contains an untransferred byte.
REQ-009 frame_err  output  1  single-cycle pulse on a bad stop bit.
REQ-010 overrun  output  1  sticky; a completed byte was dropped.
REQ-011 busy  output  1  high in every FSM state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rxs.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; a bit-timer counts 0..DIV-1; a 3-bit index counts data bits.
REQ-014 IDLE: rxs=0 -> START with timer cleared; otherwise remain.
REQ-015 START: at timer=DIV/2-1, sample rxs; 1 -> IDLE (glitch rejected, no flag); 0 -> DATA with timer and index cleared.
REQ-016 DATA: at each timer=DIV-1, shift rxs into bit[index] (LSB first) and wrap the timer to 0; after index 7 -> STOP.
REQ-017 STOP: at timer=DIV-1, sample rxs; 1 -> byte complete, -> IDLE; 0 -> frame_err=1 for that one cycle, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxs=1, then -> IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 Byte complete with rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: load rx_data, rx_valid=1 next cycle.
REQ-020 Byte complete with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun=1 next cycle.
REQ-021 Handshake with no completing byte: rx_valid=0 next cycle; rx_data holds its last value.
REQ-022 overrun clears on ovr_clr=1; if a set event coincides with ovr_clr, set wins.
REQ-023 Latency: rx_valid rises 1 cycle after the stop-bit sample cycle; the stop sample occurs (DIV/2 + 9*DIV) cycles after the first cycle rxs=0 in IDLE.
REQ-024 rx_ready and ovr_clr SHALL be ignored while rx_valid/overrun respectively are already low (no side effects).

Reset
REQ-025 While rst=1: FSM=IDLE, timer=0, index=0, synchronizer=1/1, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no byte, no frame_err and no overrun; after release, reception restarts only on a new falling edge.

Verification (DIV=8)
REQ-027 Send 0xA5 with rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err never pulses; assert rx_ready for 1 cycle -> rx_valid=0.
REQ-028 Send 0x3C then 0x81 back-to-back with rx_ready=0 -> rx_data stays 0x3C, overrun=1; pulse ovr_clr -> overrun=0.
REQ-029 Send 0x55 with stop bit=0, then hold rx low 40 cycles -> exactly one frame_err pulse, rx_valid stays 0, busy=1 until rx returns high.
REQ-030 Low glitch of 2 cycles on idle line -> FSM returns to IDLE, no rx_valid, no frame_err.
REQ-031 Assert rst during bit 4 of 0xFF, release, send 0x12 -> only 0x12 is delivered, flags 0.
REQ-032 Keep rx_ready=1, send 0x00 then 0xFF back-to-back -> both bytes delivered in order, each rx_valid high exactly one cycle, overrun=0.
